// File: rtl/mem_arbiter.sv
// Two-core I/D memory arbiter onto one shared RAM port; data before instruction, round-robin between cores.
// Define MEM_ARB_ATOMIC_EN to compile in per-core LL/SC link registers.
module mem_arbiter #(
  parameter int NCORE = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NCORE-1:0]       iREN,
  input  logic [NCORE-1:0][31:0] iaddr,
  input  logic [NCORE-1:0]       dREN,
  input  logic [NCORE-1:0]       dWEN,
  input  logic [NCORE-1:0]       datomic,
  input  logic [NCORE-1:0][31:0] daddr,
  input  logic [NCORE-1:0][31:0] dstore,
  output logic [NCORE-1:0]       iwait,
  output logic [NCORE-1:0]       dwait,
  output logic [NCORE-1:0][31:0] iload,
  output logic [NCORE-1:0][31:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  logic [1:0]             ramstate
);

  localparam logic [0:0] IDLE       = 1'b0;
  localparam logic [0:0] SERVE      = 1'b1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
`ifdef MEM_ARB_ATOMIC_EN
  localparam logic ATOMIC_EN = 1'b1;
`else
  localparam logic ATOMIC_EN = 1'b0;
`endif

  logic [0:0]       state_q, state_d;
  logic             rr_q, rr_d;
  logic             own_core_q, own_core_d;
  logic             own_dat_q, own_dat_d;
  logic             own_wr_q, own_wr_d;
  logic             own_atom_q, own_atom_d;
  logic             own_scfail_q, own_scfail_d;
  logic [31:0]      own_addr_q, own_addr_d;
  logic [31:0]      own_data_q, own_data_d;

  logic [NCORE-1:0] req;
  logic [NCORE-1:0] link_hit;
  logic             gnt;
  logic             own_req;
  logic             done;
  logic [31:0]      ld_val;

  always_comb begin
    req          = iREN | dREN | dWEN;
    gnt          = (req[0] && req[1]) ? ~rr_q : req[1];
    own_req      = own_dat_q ? (dREN[own_core_q] | dWEN[own_core_q]) : iREN[own_core_q];
    state_d      = state_q;
    rr_d         = rr_q;
    own_core_d   = own_core_q;
    own_dat_d    = own_dat_q;
    own_wr_d     = own_wr_q;
    own_atom_d   = own_atom_q;
    own_scfail_d = own_scfail_q;
    own_addr_d   = own_addr_q;
    own_data_d   = own_data_q;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d      = SERVE;
          own_core_d   = gnt;
          own_dat_d    = dREN[gnt] | dWEN[gnt];
          own_wr_d     = dWEN[gnt];
          own_atom_d   = ATOMIC_EN & own_dat_d & datomic[gnt];
          // SC link is judged at grant; no write can complete between grant and service
          own_scfail_d = own_atom_d & dWEN[gnt] & ~link_hit[gnt];
          own_addr_d   = own_dat_d ? daddr[gnt] : iaddr[gnt];
          own_data_d   = dstore[gnt];
        end
      end
      default: begin
        if (!own_req) begin
          state_d = IDLE;
        end else if (own_scfail_q || ramstate == RAM_ACCESS) begin
          done    = 1'b1;
          state_d = IDLE;
          rr_d    = own_core_q;
        end
      end
    endcase
  end

  assign ramREN   = (state_q == SERVE) && !own_scfail_q && !own_wr_q;
  assign ramWEN   = (state_q == SERVE) && !own_scfail_q && own_wr_q;
  assign ramaddr  = own_addr_q;
  assign ramstore = own_data_q;

  always_comb begin
    ld_val = own_wr_q ? {31'b0, own_atom_q & ~own_scfail_q} : ramload;
    iwait  = '1;
    dwait  = '1;
    iload  = '0;
    dload  = '0;
    if (done) begin
      if (own_dat_q) begin
        dwait[own_core_q] = 1'b0;
        dload[own_core_q] = ld_val;
      end else begin
        iwait[own_core_q] = 1'b0;
        iload[own_core_q] = ld_val;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      rr_q         <= 1'b1;
      own_core_q   <= 1'b0;
      own_dat_q    <= 1'b0;
      own_wr_q     <= 1'b0;
      own_atom_q   <= 1'b0;
      own_scfail_q <= 1'b0;
      own_addr_q   <= '0;
      own_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      own_core_q   <= own_core_d;
      own_dat_q    <= own_dat_d;
      own_wr_q     <= own_wr_d;
      own_atom_q   <= own_atom_d;
      own_scfail_q <= own_scfail_d;
      own_addr_q   <= own_addr_d;
      own_data_q   <= own_data_d;
    end
  end

`ifdef MEM_ARB_ATOMIC_EN
  logic [NCORE-1:0]       link_v_q, link_v_d;
  logic [NCORE-1:0][29:0] link_a_q, link_a_d;

  always_comb begin
    link_v_d = link_v_q;
    link_a_d = link_a_q;
    for (int c = 0; c < NCORE; c++) begin
      link_hit[c] = link_v_q[c] && (link_a_q[c] == daddr[c][31:2]);
    end
    // A completed write kills every link on that word, the writer's own included
    if (done && own_wr_q && !own_scfail_q) begin
      for (int c = 0; c < NCORE; c++) begin
        if (link_a_q[c] == own_addr_q[31:2]) link_v_d[c] = 1'b0;
      end
    end
    if (done && own_atom_q && !own_wr_q) begin
      link_v_d[own_core_q] = 1'b1;
      link_a_d[own_core_q] = own_addr_q[31:2];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_v_q <= '0;
      link_a_q <= '0;
    end else begin
      link_v_q <= link_v_d;
      link_a_q <= link_a_d;
    end
  end
`else
  assign link_hit = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected completions, a negedge monitor checks them.
module tb_mem_arbiter;

  logic             CLK  = 1'b0;
  logic             nRST = 1'b1;
  logic [1:0]       iREN = '0, dREN = '0, dWEN = '0, datomic = '0;
  logic [1:0][31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic [1:0]       iwait, dwait;
  logic [1:0][31:0] iload, dload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int lat = 0;
  int ram_cnt = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    bit          core;
    bit          dport;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;
  exp_t expq[$];

  always #5 CLK = ~CLK;

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  // RAM model: `lat` BUSY cycles, then ACCESS; read data derived from the address
  assign ramload  = {ramaddr[15:0], 16'hC0DE};
  assign ramstate = !(ramREN || ramWEN) ? 2'd0 : ((ram_cnt >= lat) ? 2'd2 : 2'd1);
  always @(posedge CLK) ram_cnt <= (!(ramREN || ramWEN) || ramstate == 2'd2) ? 0 : ram_cnt + 1;

  function automatic logic [31:0] rdval(input logic [31:0] a);
    return {a[15:0], 16'hC0DE};
  endfunction

  function automatic exp_t mk(input bit core, input bit dport, input bit ren, input bit wen,
                              input logic [31:0] addr, input logic [31:0] store, input logic [31:0] load);
    exp_t e;
    e.core = core; e.dport = dport; e.ren = ren; e.wen = wen;
    e.addr = addr; e.store = store; e.load = load;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge CLK) begin
    if (nRST) begin
      for (int c = 0; c < 2; c++) begin
        for (int p = 0; p < 2; p++) begin
          logic        w;
          logic [31:0] ld;
          exp_t        e;
          w  = (p == 1) ? dwait[c] : iwait[c];
          ld = (p == 1) ? dload[c] : iload[c];
          if (!w) begin
            chk($sformatf("completion_expected c%0d p%0d", c, p), 64'(expq.size() > 0), 64'(1'b1));
            if (expq.size() > 0) begin
              e = expq.pop_front();
              chk("mon_owner", 64'({c[0], p[0]}), 64'({e.core, e.dport}));
              chk("mon_strobes", 64'({ramREN, ramWEN}), 64'({e.ren, e.wen}));
              if (e.ren || e.wen) chk("mon_ramaddr", 64'(ramaddr), 64'(e.addr));
              if (e.wen) chk("mon_ramstore", 64'(ramstore), 64'(e.store));
              chk("mon_load", 64'(ld), 64'(e.load));
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #1 nRST = 1'b0;
    @(negedge CLK);
    #1 nRST = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output int stb);
    bit got;
    got = 1'b0;
    cyc = 0;
    stb = 0;
    while (!got && cyc < max_cyc) begin
      @(negedge CLK);
      cyc++;
      if (ramREN || ramWEN) stb++;
      got = !((&iwait) && (&dwait));
    end
    if (!got) begin
      n_chk++;
      $display("FAIL done_timeout: no completion after %0d cycles", cyc);
    end
    tick();
  endtask

  task automatic d_op(input bit core, input bit wr, input bit atom, input logic [31:0] a,
                      input logic [31:0] st, input exp_t e, output int cyc);
    int stb;
    daddr[core]   = a;
    dstore[core]  = st;
    datomic[core] = atom;
    dREN[core]    = !wr;
    dWEN[core]    = wr;
    expq.push_back(e);
    wait_done(30, cyc, stb);
    dREN[core]    = 1'b0;
    dWEN[core]    = 1'b0;
    datomic[core] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, stb;
    #1 nRST = 1'b0;
    #1;
    chk("rst_iwait", 64'(iwait), 64'(2'b11));
    chk("rst_dwait", 64'(dwait), 64'(2'b11));
    chk("rst_iload", iload, 64'h0);
    chk("rst_dload", dload, 64'h0);
    chk("rst_strobes", 64'({ramREN, ramWEN}), 64'(2'b00));
    chk("rst_ramaddr", 64'(ramaddr), 64'h0);
    chk("rst_ramstore", 64'(ramstore), 64'h0);
    @(negedge CLK);
    #1 nRST = 1'b1;
    tick();

    // instruction read with two BUSY cycles
    lat = 2;
    iaddr[0] = 32'h100;
    iREN[0]  = 1'b1;
    expq.push_back(mk(0, 0, 1, 0, 32'h100, 32'h0, rdval(32'h100)));
    wait_done(20, cyc, stb);
    iREN[0] = 1'b0;
    chk("t1_latency", 64'(cyc), 64'(4));
    chk("t1_ren_cycles", 64'(stb), 64'(3));

    // both cores streaming reads: 0,1,0,1, one completion every other cycle
    do_reset();
    lat = 0;
    daddr[0] = 32'h300;
    daddr[1] = 32'h304;
    dREN     = 2'b11;
    expq.push_back(mk(0, 1, 1, 0, 32'h300, 32'h0, rdval(32'h300)));
    expq.push_back(mk(1, 1, 1, 0, 32'h304, 32'h0, rdval(32'h304)));
    expq.push_back(mk(0, 1, 1, 0, 32'h300, 32'h0, rdval(32'h300)));
    expq.push_back(mk(1, 1, 1, 0, 32'h304, 32'h0, rdval(32'h304)));
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      chk($sformatf("t2_done_cycle%0d", k), 64'(!((&iwait) && (&dwait))), 64'(k % 2 == 0));
    end
    tick();
    dREN = 2'b00;

    // same-core I + D (with dREN and dWEN both high): write goes first
    iaddr[0]  = 32'h200;
    daddr[0]  = 32'h200;
    dstore[0] = 32'hDEADBEEF;
    iREN[0]   = 1'b1;
    dREN[0]   = 1'b1;
    dWEN[0]   = 1'b1;
    expq.push_back(mk(0, 1, 0, 1, 32'h200, 32'hDEADBEEF, 32'h0));
    expq.push_back(mk(0, 0, 1, 0, 32'h200, 32'h0, rdval(32'h200)));
    wait_done(20, cyc, stb);
    dREN[0] = 1'b0;
    dWEN[0] = 1'b0;
    wait_done(20, cyc, stb);
    iREN[0] = 1'b0;

    // core 1 drops its request mid-SERVE: no completion, strobe gone one cycle later
    lat = 6;
    iaddr[1] = 32'h500;
    iREN[1]  = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t4_ren_before_drop", 64'(ramREN), 64'(1'b1));
    tick();
    iREN[1] = 1'b0;
    repeat (2) @(negedge CLK);
    chk("t4_ren_after_drop", 64'(ramREN), 64'(1'b0));
    tick();

    // pointer still names core 0 as last served, so core 1 wins this tie
    lat = 0;
    iaddr[0] = 32'h600;
    iaddr[1] = 32'h604;
    iREN     = 2'b11;
    expq.push_back(mk(1, 0, 1, 0, 32'h604, 32'h0, rdval(32'h604)));
    expq.push_back(mk(0, 0, 1, 0, 32'h600, 32'h0, rdval(32'h600)));
    wait_done(20, cyc, stb);
    iREN[1] = 1'b0;
    wait_done(20, cyc, stb);
    iREN[0] = 1'b0;

`ifdef MEM_ARB_ATOMIC_EN
    d_op(0, 0, 1, 32'h40, 32'h0, mk(0, 1, 1, 0, 32'h40, 32'h0, rdval(32'h40)), cyc);
    d_op(1, 1, 0, 32'h40, 32'h1111, mk(1, 1, 0, 1, 32'h40, 32'h1111, 32'h0), cyc);
    d_op(0, 1, 1, 32'h40, 32'hAAAA, mk(0, 1, 0, 0, 32'h40, 32'hAAAA, 32'h0), cyc);
    chk("sc_fail_latency", 64'(cyc), 64'(2));
    d_op(0, 0, 1, 32'h40, 32'h0, mk(0, 1, 1, 0, 32'h40, 32'h0, rdval(32'h40)), cyc);
    d_op(0, 1, 1, 32'h40, 32'hBBBB, mk(0, 1, 0, 1, 32'h40, 32'hBBBB, 32'h1), cyc);
    d_op(0, 1, 1, 32'h40, 32'hCCCC, mk(0, 1, 0, 0, 32'h40, 32'hCCCC, 32'h0), cyc);
`else
    d_op(0, 0, 1, 32'h40, 32'h0, mk(0, 1, 1, 0, 32'h40, 32'h0, rdval(32'h40)), cyc);
    d_op(0, 1, 1, 32'h40, 32'hBBBB, mk(0, 1, 0, 1, 32'h40, 32'hBBBB, 32'h0), cyc);
`endif

    // reset pulse while a write is being served
    d_op(0, 0, 1, 32'h40, 32'h0, mk(0, 1, 1, 0, 32'h40, 32'h0, rdval(32'h40)), cyc);
    lat = 5;
    daddr[0]  = 32'h80;
    dstore[0] = 32'h1234;
    dWEN[0]   = 1'b1;
    repeat (2) @(negedge CLK);
    chk("t6_wen_before_rst", 64'(ramWEN), 64'(1'b1));
    #1 nRST = 1'b0;
    #1;
    chk("t6_wen_in_rst", 64'(ramWEN), 64'(1'b0));
    chk("t6_waits_in_rst", 64'({iwait, dwait}), 64'(4'b1111));
    chk("t6_dload_in_rst", dload, 64'h0);
    dWEN[0] = 1'b0;
    @(negedge CLK);
    #1 nRST = 1'b1;
    tick();
    lat = 0;
`ifdef MEM_ARB_ATOMIC_EN
    d_op(0, 1, 1, 32'h40, 32'hDDDD, mk(0, 1, 0, 0, 32'h40, 32'hDDDD, 32'h0), cyc);
`else
    d_op(0, 1, 1, 32'h40, 32'hDDDD, mk(0, 1, 0, 1, 32'h40, 32'hDDDD, 32'h0), cyc);
`endif

    repeat (3) @(negedge CLK);
    chk("queue_drained", 64'(expq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-core memory arbiter sitting between the per-core instruction/data cache ports and the single shared RAM. Selects one of up to four pending requests (I and D per core), drives the RAM until it reports ACCESS, then releases the requester's wait. Tracks per-core LL/SC link registers so that a store-conditional from the pipeline's `datomic` path succeeds only when no intervening write hit the linked word.

## Interface
- `NCORE`, 2, number of cores. Fixed; other values unsupported.
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `iREN[c]`  in  1  instruction read request, core c (c = 0,1).
- `iaddr[c]`  in  32  instruction word address.
- `dREN[c]` / `dWEN[c]`  in  1  data read / write request.
- `datomic[c]`  in  1  qualifies dREN as LL, dWEN as SC.
- `daddr[c]`  in  32  data word address.
- `dstore[c]`  in  32  write data.
- `iwait[c]` / `dwait[c]`  out  1  request still pending; low for exactly one cycle on completion.
- `iload[c]` / `dload[c]`  out  32  read data (SC: success flag).
- `ramREN` / `ramWEN`  out  1  RAM read / write strobe.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- States: IDLE, SERVE.
- IDLE: if any request active, register owner (core, I/D, addr, data, kind) and go SERVE; otherwise stay. RAM strobes low.
- Priority: within a core, data over instruction. Between cores, round-robin: the core not served last wins when both request; pointer initialised to core 1 (so core 0 wins first tie).
- SERVE: drive `ramREN`/`ramWEN`, `ramaddr`, `ramstore` from registered owner. On `ramstate==ACCESS`: owner's wait low this cycle, load output = `ramload` (reads), flip round-robin pointer to owner, next state IDLE.
- `ramstate` BUSY, FREE, ERROR: stay in SERVE, hold strobes (ERROR retried).
- Owner drops its request while in SERVE: strobes deassert next cycle, go IDLE, no completion, pointer unchanged.
- Writes never both R and W: dWEN takes precedence if a core asserts dREN and dWEN together.
- Non-owner waits stay high; waits for idle (no request) ports are high.
- Addresses compared on bits [31:2].

## Timing
- Reset: state IDLE, pointer core 1, all waits 1, all loads 0, `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0, links cleared.
- Arbitration 1 cycle (IDLE), then ≥1 SERVE cycle; minimum 2 cycles request-to-completion, 2-cycle issue interval with back-to-back requests.
- Wait deassertion and load data combinational in the ACCESS cycle; requester samples at next edge.
- Reset mid-SERVE: strobes drop asynchronously, no completion reported, links cleared.

## Configuration
- `MEM_ARB_ATOMIC_EN` defined: per-core link {valid, addr[31:2]}.
  - LL completion sets own link to daddr.
  - SC with valid matching own link: performs RAM write; on ACCESS, `dload`=1.
  - SC otherwise: no RAM strobe; completes in first SERVE cycle with `dload`=0.
  - Any completed write (SW or successful SC) from either core clears every link matching its address, including the writer's.
- Undefined: `datomic` ignored; LL behaves as LW, SC as SW with `dload`=0; no link state.

## Test plan
- Core 0 iREN at 0x100, RAM ACCESS after 2 BUSY cycles -> ramREN high for 3 SERVE cycles, iwait[0] low in cycle 4 with iload[0]=ramload; completion on cycle 4 after request.
- Both cores dREN constantly, RAM ACCESS immediately -> grants alternate 0,1,0,1; each completes every 4 cycles.
- Core 0 iREN and dWEN same cycle (0x200, 0xDEADBEEF) -> data write served first (ramWEN, ramstore=0xDEADBEEF), instruction next.
- ATOMIC_EN: core 0 LL 0x40, core 1 SW 0x40, core 0 SC 0x40 -> SC completes with no ramWEN, dload[0]=0; repeat without core 1 SW -> ramWEN, dload[0]=1.
- ATOMIC_EN: core 0 LL 0x40, core 0 SC 0x40 succeeds, second SC 0x40 -> fails (dload[0]=0).
- nRST pulse during SERVE with ramWEN high -> ramWEN 0 immediately, all waits 1, subsequent SC fails.
